change_dispenser: RTL and testbench

- Downstream stage of vending_machine: takes the change amount the machine computes after a sale and ejects it as physical coins.
- Drives a three-tube coin hopper (25c, 10c, 5c) one coin at a time over a req/ack handshake.
- Selects coins greedily, tracks per-tube inventory, and reports any shortfall it cannot pay.

---
 rtl/change_pkg.sv | 11 +
 rtl/coin_tube_counter.sv | 22 ++
 rtl/change_dispenser.sv | 161 ++++++++++++++++
 tb/tb_change_dispenser.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/change_pkg.sv
// change_pkg: shared state/coin encodings and coin values for change_dispenser.
package change_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_e;
   typedef enum logic [1:0] {C25, C10, C5, CNONE} coin_e;
   localparam int COIN_25 = 25;
   localparam int COIN_10 = 10;
   localparam int COIN_5  = 5;
   function automatic int coin_value(coin_e c);
      return c == C25 ? COIN_25 : c == C10 ? COIN_10 : c == C5 ? COIN_5 : 0;
   endfunction
endpackage

// File: rtl/coin_tube_counter.sv
// coin_tube_counter: saturating per-tube coin inventory; simultaneous inc and dec cancel out.
module coin_tube_counter #(
   parameter int INV_W    = 8,
   parameter int INV_INIT = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [INV_W-1:0] count
);
   logic [INV_W-1:0] count_q, count_d;
   always_comb begin
      count_d = (inc && !dec && count_q != '1) ? count_q + 1'b1 :
                (dec && !inc && count_q != '0) ? count_q - 1'b1 : count_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= INV_W'(INV_INIT);
      else        count_q <= count_d;
   end
   assign count = count_q;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 25/10/5 coin payout over a hopper req/ack handshake.
// Define CHANGE_DISPENSER_ACK_TIMEOUT_EN to abort a payout when the hopper never acks.
module change_dispenser
   import change_pkg::*;
#(
   parameter int AMT_W      = 8,
   parameter int INV_W      = 8,
   parameter int INV_INIT   = 20,
   parameter int GAP_CYCLES = 4
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
   ,
   parameter int ACK_TIMEOUT = 255
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             change_load,
   input  logic [AMT_W-1:0] change_amount,
   input  logic             hopper_ack,
   input  logic             refill_25,
   input  logic             refill_10,
   input  logic             refill_5,
   output logic             eject_25,
   output logic             eject_10,
   output logic             eject_5,
   output logic             busy,
   output logic             done,
   output logic [AMT_W-1:0] shortfall,
   output logic             load_reject,
   output logic [INV_W-1:0] inv_25,
   output logic [INV_W-1:0] inv_10,
   output logic [INV_W-1:0] inv_5
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
   ,
   output logic             ack_timeout
`endif
);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   state_e           state_q, state_d;
   coin_e            coin_q, coin_d, sel;
   logic [AMT_W-1:0] remaining_q, remaining_d, shortfall_q, shortfall_d;
   logic [2:0]       eject_q, eject_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             busy_q, busy_d, done_q, done_d, load_reject_q, load_reject_d, take;
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             ack_timeout_q, ack_timeout_d;
`endif
   // Greedy pick, largest coin first, skipping empty tubes.
   always_comb begin
      sel = (remaining_q >= AMT_W'(COIN_25) && inv_25 != '0) ? C25 :
            (remaining_q >= AMT_W'(COIN_10) && inv_10 != '0) ? C10 :
            (remaining_q >= AMT_W'(COIN_5)  && inv_5  != '0) ? C5  : CNONE;
   end
   assign take = state_q == EJECT && hopper_ack;
   always_comb begin
      state_d       = state_q;
      coin_d        = coin_q;
      remaining_d   = remaining_q;
      shortfall_d   = shortfall_q;
      eject_d       = eject_q;
      gap_d         = gap_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      load_reject_d = change_load && busy_q;
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
      tmo_d         = tmo_q;
      ack_timeout_d = 1'b0;
`endif
      case (state_q)
         IDLE: if (change_load) begin
            remaining_d = change_amount;
            shortfall_d = '0;
            busy_d      = 1'b1;
            state_d     = SELECT;
         end
         SELECT: if (sel == CNONE) begin
            done_d      = 1'b1;
            shortfall_d = remaining_q;
            state_d     = FINISH;
         end else begin
            coin_d  = sel;
            eject_d = {sel == C25, sel == C10, sel == C5};
            state_d = EJECT;
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         EJECT: if (hopper_ack) begin
            eject_d     = '0;
            remaining_d = remaining_q - AMT_W'(coin_value(coin_q));
            gap_d       = '0;
            state_d     = GAP;
         end
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
         else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            eject_d       = '0;
            done_d        = 1'b1;
            ack_timeout_d = 1'b1;
            shortfall_d   = remaining_q;
            state_d       = FINISH;
         end else tmo_d = tmo_q + 1'b1;
`endif
         GAP: if (hopper_ack) gap_d = '0;
            else if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = SELECT;
            else gap_d = gap_q + 1'b1;
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         coin_q        <= CNONE;
         remaining_q   <= '0;
         shortfall_q   <= '0;
         eject_q       <= '0;
         gap_q         <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         load_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         coin_q        <= coin_d;
         remaining_q   <= remaining_d;
         shortfall_q   <= shortfall_d;
         eject_q       <= eject_d;
         gap_q         <= gap_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         load_reject_q <= load_reject_d;
      end
   end
`ifdef CHANGE_DISPENSER_ACK_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q         <= '0;
         ack_timeout_q <= 1'b0;
      end else begin
         tmo_q         <= tmo_d;
         ack_timeout_q <= ack_timeout_d;
      end
   end
   assign ack_timeout = ack_timeout_q;
`endif
   coin_tube_counter #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_tube_25 (
      .clk(clk), .rst_n(rst_n), .inc(refill_25), .dec(take && coin_q == C25), .count(inv_25));
   coin_tube_counter #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_tube_10 (
      .clk(clk), .rst_n(rst_n), .inc(refill_10), .dec(take && coin_q == C10), .count(inv_10));
   coin_tube_counter #(.INV_W(INV_W), .INV_INIT(INV_INIT)) u_tube_5 (
      .clk(clk), .rst_n(rst_n), .inc(refill_5), .dec(take && coin_q == C5), .count(inv_5));
   assign {eject_25, eject_10, eject_5} = eject_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign shortfall   = shortfall_q;
   assign load_reject = load_reject_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: random payouts checked against a greedy arithmetic model of coins and tubes.
module tb_change_dispenser;
   logic clk = 1'b0, rst_n = 1'b1, change_load = 1'b0, hopper_ack = 1'b0;
   logic refill_25 = 1'b0, refill_10 = 1'b0, refill_5 = 1'b0;
   logic [7:0] change_amount = '0;
   logic eject_25, eject_10, eject_5, busy, done, load_reject;
   logic [7:0] shortfall, inv_25, inv_10, inv_5;
   int total = 0, bad = 0;
   int m_inv[3];
   int got[$];
   bit hop_en = 1'b1;
   int ack_dly = -1;
   always #5 clk = ~clk;
   change_dispenser dut (
      .clk(clk), .rst_n(rst_n), .change_load(change_load), .change_amount(change_amount),
      .hopper_ack(hopper_ack), .refill_25(refill_25), .refill_10(refill_10), .refill_5(refill_5),
      .eject_25(eject_25), .eject_10(eject_10), .eject_5(eject_5), .busy(busy), .done(done),
      .shortfall(shortfall), .load_reject(load_reject), .inv_25(inv_25), .inv_10(inv_10), .inv_5(inv_5));
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
      end
   endtask
   task automatic chk_inv();
      chk("inv_25", inv_25, m_inv[0]);
      chk("inv_10", inv_10, m_inv[1]);
      chk("inv_5", inv_5, m_inv[2]);
   endtask
   // Hopper: logs each requested coin, acks after a delay, holds ack for a few cycles.
   initial forever begin
      @(negedge clk);
      if (hop_en && rst_n && (eject_25 || eject_10 || eject_5)) begin
         int c, d;
         chk("onehot", $countones({eject_25, eject_10, eject_5}), 1);
         c = eject_25 ? 25 : eject_10 ? 10 : 5;
         got.push_back(c);
         d = ack_dly < 0 ? int'($urandom_range(0, 4)) : ack_dly;
         repeat (d) @(negedge clk);
         chk("eject_held", eject_25 ? 25 : eject_10 ? 10 : eject_5 ? 5 : 0, c);
         hopper_ack = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         hopper_ack = 1'b0;
      end
   end
   task automatic pay(input int amt, input bit rej);
      int rem, n;
      int val[3];
      int exp_q[$];
      val = '{25, 10, 5};
      rem = amt;
      n = 0;
      while (1) begin
         int k;
         k = -1;
         for (int i = 0; i < 3; i++) if (k < 0 && rem >= val[i] && m_inv[i] > 0) k = i;
         if (k < 0) break;
         exp_q.push_back(val[k]);
         rem -= val[k];
         m_inv[k]--;
      end
      got.delete();
      change_amount = amt[7:0];
      change_load = 1'b1;
      @(negedge clk);
      change_load = 1'b0;
      chk("busy_rise", busy, 1);
      chk("no_reject", load_reject, 0);
      if (rej) begin
         change_amount = 8'd30;
         change_load = 1'b1;
         @(negedge clk);
         change_load = 1'b0;
         chk("load_reject", load_reject, 1);
         n = 1;
      end
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
      if (exp_q.size() == 0) chk("latency", n, 1);
      chk("shortfall", shortfall, rem);
      chk("coin_count", got.size(), exp_q.size());
      foreach (exp_q[i]) if (i < got.size()) chk("coin", got[i], exp_q[i]);
      chk_inv();
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_fall", busy, 0);
      chk("shortfall_hold", shortfall, rem);
   endtask
   task automatic refill(input int i);
      {refill_25, refill_10, refill_5} = 3'b100 >> i;
      @(negedge clk);
      {refill_25, refill_10, refill_5} = 3'b000;
      if (m_inv[i] < 255) m_inv[i]++;
   endtask
   initial begin
      int n;
      m_inv = '{20, 20, 20};
      #2 rst_n = 1'b0;
      #10;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_eject", {eject_25, eject_10, eject_5}, 0);
      chk("rst_shortfall", shortfall, 0);
      chk("rst_reject", load_reject, 0);
      chk_inv();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ack_dly = 3;
      pay(75, 0);
      pay(40, 0);
      ack_dly = -1;
      pay(0, 0);
      pay(3, 0);
      pay(40, 1);
      hop_en = 1'b0;
      change_amount = 8'd10;
      change_load = 1'b1;
      @(negedge clk);
      change_load = 1'b0;
      n = 0;
      while (!eject_10 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("eject10_up", eject_10, 1);
      #2 rst_n = 1'b0;
      #1;
      m_inv = '{20, 20, 20};
      chk("mid_rst_eject", eject_10, 0);
      chk("mid_rst_busy", busy, 0);
      chk_inv();
      @(negedge clk);
      rst_n = 1'b1;
      hop_en = 1'b1;
      @(negedge clk);
      pay(5, 0);
      pay(250, 0);
      pay(250, 0);
      pay(60, 0);
      refill(0);
      pay(60, 0);
      for (int t = 0; t < 20; t++) begin
         repeat ($urandom_range(0, 3)) refill(int'($urandom_range(0, 2)));
         pay(int'($urandom_range(0, 255)), t % 5 == 0);
      end
      repeat (260) refill(2);
      chk_inv();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
